// File: rtl/distance_fare_tiered.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : distance_fare_tiered
// Brief    : BCD taxi distance/fare meter with a free base distance and a
//            two-tier per-pulse rate; fare and distance saturate independently.
// Revision : 1.0 - initial release
// ============================================================================
module distance_fare_tiered #(
    parameter int                       DIST_DIGITS = 4,
    parameter int                       FARE_DIGITS = 4,
    parameter int                       RATE_DIGITS = 3,
    parameter logic [DIST_DIGITS*4-1:0] BASE_DIST   = 'h0300,
    parameter logic [DIST_DIGITS*4-1:0] TIER_DIST   = 'h1000
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         pulse_in,
    input  logic                         en,
    input  logic                         wait_en,
    input  logic                         max_in,
    input  logic                         clr,
    input  logic [FARE_DIGITS*4-1:0]     start_fare,
    input  logic [RATE_DIGITS*4-1:0]     rate_base,
    input  logic [RATE_DIGITS*4-1:0]     rate_far,
    output logic [DIST_DIGITS*4-1:0]     distance_bcd,
    output logic [(DIST_DIGITS-2)*4-1:0] distance_km,
    output logic [FARE_DIGITS*4-1:0]     fare_bcd,
    output logic                         fare_max,
    output logic                         dist_max,
    output logic                         tier_far,
    output logic [1:0]                   state_o
);

    localparam int c_dist_w = DIST_DIGITS * 4;
    localparam int c_fare_w = FARE_DIGITS * 4;
    localparam int c_rate_w = RATE_DIGITS * 4;
    localparam int c_km_w   = (DIST_DIGITS - 2) * 4;
    localparam logic [c_fare_w-1:0] c_fare_all9 = {FARE_DIGITS{4'h9}};

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_BASE  = 2'b01,
        S_METER = 2'b10,
        S_SAT   = 2'b11
    } state_t;

    state_t              r_state;
    state_t              w_state_nx;
    logic [c_dist_w-1:0] r_dist;
    logic [c_dist_w-1:0] w_dist_nx;
    logic [c_fare_w-1:0] r_fare;
    logic [c_fare_w-1:0] w_fare_nx;
    logic                r_fare_max;
    logic                w_fare_max_nx;
    logic                r_dist_max;
    logic                w_dist_max_nx;

    logic [2:0]          r_sync;
    logic                w_ev;
    logic                w_cnt;
    logic                w_hold;
    logic                w_tier;

    logic [c_dist_w-1:0] w_dist_inc;
    logic [c_dist_w-1:0] w_dist_step;
    logic [DIST_DIGITS:0] w_dcarry;
    logic                w_dist_ovf;

    logic [c_rate_w-1:0] w_rate;
    logic [c_fare_w-1:0] w_rate_ext;
    logic [c_fare_w-1:0] w_fare_sum;
    logic [FARE_DIGITS:0] w_fcarry;

    // Two flops resynchronise the raw pulse; the third holds the previous level
    // so only the rising edge produces a single-cycle event.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= 3'b000;
        end else begin
            r_sync <= {r_sync[1:0], pulse_in};
        end
    end

    assign w_ev   = r_sync[1] & ~r_sync[2];
    assign w_hold = ~en | wait_en | max_in;
    assign w_cnt  = w_ev & ~w_hold & ~clr;
    assign w_tier = (r_dist >= TIER_DIST);

    // BCD +1 with ripple carry; a carry out of the top digit means all-9s.
    assign w_dcarry[0] = 1'b1;
    for (genvar i = 0; i < DIST_DIGITS; i++) begin : g_dist_inc
        logic [3:0] w_digit;
        assign w_digit                = r_dist[i*4 +: 4];
        assign w_dist_inc[i*4 +: 4]   = !w_dcarry[i]     ? w_digit :
                                        (w_digit == 4'd9) ? 4'd0    : w_digit + 4'd1;
        assign w_dcarry[i+1]          = w_dcarry[i] & (w_digit == 4'd9);
    end

    assign w_dist_ovf  = w_dcarry[DIST_DIGITS];
    assign w_dist_step = w_dist_ovf ? r_dist : w_dist_inc;

    // Tier is chosen on the distance before this pulse is added.
    assign w_rate     = w_tier ? rate_far : rate_base;
    assign w_rate_ext = c_fare_w'(w_rate);

    assign w_fcarry[0] = 1'b0;
    for (genvar i = 0; i < FARE_DIGITS; i++) begin : g_fare_add
        logic [4:0] w_sum;
        assign w_sum                = {1'b0, r_fare[i*4 +: 4]} + {1'b0, w_rate_ext[i*4 +: 4]}
                                      + {4'd0, w_fcarry[i]};
        assign w_fare_sum[i*4 +: 4] = (w_sum > 5'd9) ? w_sum[3:0] + 4'd6 : w_sum[3:0];
        assign w_fcarry[i+1]        = (w_sum > 5'd9);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_dist     <= '0;
            r_fare     <= '0;
            r_fare_max <= 1'b0;
            r_dist_max <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_dist     <= w_dist_nx;
            r_fare     <= w_fare_nx;
            r_fare_max <= w_fare_max_nx;
            r_dist_max <= w_dist_max_nx;
        end
    end

    always_comb begin
        w_state_nx    = r_state;
        w_dist_nx     = r_dist;
        w_fare_nx     = r_fare;
        w_fare_max_nx = r_fare_max;
        w_dist_max_nx = r_dist_max;

        if (clr) begin
            w_state_nx    = S_IDLE;
            w_dist_nx     = '0;
            w_fare_nx     = '0;
            w_fare_max_nx = 1'b0;
            w_dist_max_nx = 1'b0;
        end else if (!w_hold) begin
            case (r_state)
                S_IDLE: begin
                    // Events seen while arming the trip are not counted.
                    w_state_nx = S_BASE;
                    w_fare_nx  = start_fare;
                end
                S_BASE: begin
                    if (w_cnt) begin
                        w_dist_nx     = w_dist_step;
                        w_dist_max_nx = r_dist_max | w_dist_ovf;
                        if (w_dist_step == BASE_DIST) begin
                            w_state_nx = S_METER;
                        end
                    end
                end
                S_METER: begin
                    if (w_cnt) begin
                        w_dist_nx     = w_dist_step;
                        w_dist_max_nx = r_dist_max | w_dist_ovf;
                        if (w_fcarry[FARE_DIGITS]) begin
                            w_fare_nx     = c_fare_all9;
                            w_fare_max_nx = 1'b1;
                            w_state_nx    = S_SAT;
                        end else begin
                            w_fare_nx = w_fare_sum;
                        end
                    end
                end
                S_SAT: begin
                    if (w_cnt) begin
                        w_dist_nx     = w_dist_step;
                        w_dist_max_nx = r_dist_max | w_dist_ovf;
                    end
                end
                default: begin
                    w_state_nx = S_IDLE;
                end
            endcase
        end
    end

    assign distance_bcd = r_dist;
    assign distance_km  = r_dist[c_dist_w-1 -: c_km_w];
    assign fare_bcd     = r_fare;
    assign fare_max     = r_fare_max;
    assign dist_max     = r_dist_max;
    assign tier_far     = w_tier;
    assign state_o      = r_state;

endmodule
`default_nettype wire

// File: tb/tb_distance_fare_tiered.sv
`timescale 1ns/1ps
`default_nettype none
// Bench for distance_fare_tiered: a queue scoreboard checks every pulse at its
// update cycle; scenario tasks add inline checks for reset, hold, clr and limits.
module tb_distance_fare_tiered;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pulse_in = 1'b0;
    logic        en = 1'b0;
    logic        wait_en = 1'b0;
    logic        max_in = 1'b0;
    logic        clr = 1'b0;
    logic [15:0] start_fare = 16'h0;
    logic [11:0] rate_base = 12'h0;
    logic [11:0] rate_far = 12'h0;
    logic [15:0] distance_bcd;
    logic [7:0]  distance_km;
    logic [15:0] fare_bcd;
    logic        fare_max;
    logic        dist_max;
    logic        tier_far;
    logic [1:0]  state_o;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Reference model in plain binary integers.
    int m_dist, m_fare, m_state, m_sf, m_rb, m_rf;
    bit m_fmax, m_dmax;

    typedef struct {
        int          due;
        logic [36:0] vec;
    } sb_t;
    sb_t sb[$];

    distance_fare_tiered dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pulse_in     (pulse_in),
        .en           (en),
        .wait_en      (wait_en),
        .max_in       (max_in),
        .clr          (clr),
        .start_fare   (start_fare),
        .rate_base    (rate_base),
        .rate_far     (rate_far),
        .distance_bcd (distance_bcd),
        .distance_km  (distance_km),
        .fare_bcd     (fare_bcd),
        .fare_max     (fare_max),
        .dist_max     (dist_max),
        .tier_far     (tier_far),
        .state_o      (state_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin : p_watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    function automatic logic [36:0] exp_vec();
        return {to_bcd(m_dist), to_bcd(m_fare), m_fmax, m_dmax, (m_dist >= 1000), 2'(m_state)};
    endfunction

    function automatic logic [36:0] dut_vec();
        return {distance_bcd, fare_bcd, fare_max, dist_max, tier_far, state_o};
    endfunction

    function automatic void model_dist_inc();
        if (m_dist == 9999) m_dmax = 1'b1;
        else m_dist = m_dist + 1;
    endfunction

    function automatic void model_count();
        int r;
        case (m_state)
            1: begin
                model_dist_inc();
                if (m_dist == 300) m_state = 2;
            end
            2: begin
                r = (m_dist >= 1000) ? m_rf : m_rb;
                model_dist_inc();
                m_fare = m_fare + r;
                if (m_fare > 9999) begin
                    m_fare  = 9999;
                    m_fmax  = 1'b1;
                    m_state = 3;
                end
            end
            3: model_dist_inc();
            default: ;
        endcase
    endfunction

    // Scoreboard: each entry is compared on the cycle the DUT must have updated.
    initial begin : p_checker
        sb_t e;
        forever begin
            @(posedge clk);
            #1;
            while (sb.size() > 0 && sb[0].due <= cyc) begin
                e = sb.pop_front();
                checks++;
                if (dut_vec() !== e.vec || e.due != cyc) begin
                    errors++;
                    $display("FAIL sb_pulse cyc=%0d due=%0d got=%h exp=%h", cyc, e.due, dut_vec(), e.vec);
                end
            end
        end
    end

    // Called just after a falling clock edge with pulse_in low.
    task automatic drive_pulse();
        sb_t e;
        pulse_in = 1'b1;
        if (en && !wait_en && !max_in && !clr && m_state != 0) model_count();
        e.due = cyc + 3;
        e.vec = exp_vec();
        sb.push_back(e);
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk) pulse_in = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic set_fares(input int sf, input int rb, input int rf);
        m_sf = sf; m_rb = rb; m_rf = rf;
        start_fare = to_bcd(sf);
        rate_base  = 12'(to_bcd(rb));
        rate_far   = 12'(to_bcd(rf));
    endtask

    task automatic do_reset();
        rst_n = 1'b0; en = 1'b0; wait_en = 1'b0; max_in = 1'b0; clr = 1'b0; pulse_in = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        m_dist = 0; m_fare = 0; m_state = 0; m_fmax = 1'b0; m_dmax = 1'b0;
        @(negedge clk);
    endtask

    task automatic start_trip();
        en = 1'b1;
        @(negedge clk);
        m_state = 1;
        m_fare  = m_sf;
        checks++;
        if (state_o !== 2'b01 || fare_bcd !== to_bcd(m_sf) || distance_bcd !== 16'h0) begin
            errors++;
            $display("FAIL start_trip got state=%b fare=%h dist=%h exp state=01 fare=%h dist=0000",
                     state_o, fare_bcd, distance_bcd, to_bcd(m_sf));
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        en = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({distance_bcd, fare_bcd} !== 32'h0) begin
            errors++;
            $display("FAIL reset_values got dist=%h fare=%h exp 0000 0000", distance_bcd, fare_bcd);
        end
        checks++;
        if ({fare_max, dist_max, tier_far, state_o, distance_km} !== 13'h0) begin
            errors++;
            $display("FAIL reset_flags got fmax=%b dmax=%b tier=%b state=%b km=%h exp all 0",
                     fare_max, dist_max, tier_far, state_o, distance_km);
        end
        do_reset();
        set_fares(800, 2, 3);
        // With en low the meter stays idle and ignores pulses.
        for (int i = 0; i < 3; i++) drive_pulse();
    endtask

    task automatic test_base_meter();
        do_reset();
        set_fares(800, 2, 3);
        start_trip();
        for (int i = 0; i < 300; i++) drive_pulse();
        checks++;
        if (distance_bcd !== 16'h0300 || fare_bcd !== 16'h0800 || state_o !== 2'b10) begin
            errors++;
            $display("FAIL base_end got dist=%h fare=%h state=%b exp 0300 0800 10", distance_bcd, fare_bcd, state_o);
        end
        drive_pulse();
        checks++;
        if (distance_bcd !== 16'h0301 || fare_bcd !== 16'h0802) begin
            errors++;
            $display("FAIL first_meter got dist=%h fare=%h exp 0301 0802", distance_bcd, fare_bcd);
        end
        for (int i = 0; i < 699; i++) drive_pulse();
        checks++;
        if (distance_bcd !== 16'h1000 || fare_bcd !== 16'h2200 || tier_far !== 1'b1 || distance_km !== 8'h10) begin
            errors++;
            $display("FAIL tier_reach got dist=%h fare=%h tier=%b km=%h exp 1000 2200 1 10",
                     distance_bcd, fare_bcd, tier_far, distance_km);
        end
        drive_pulse();
        checks++;
        if (distance_bcd !== 16'h1001 || fare_bcd !== 16'h2203) begin
            errors++;
            $display("FAIL tier_rate got dist=%h fare=%h exp 1001 2203", distance_bcd, fare_bcd);
        end
    endtask

    task automatic test_fare_sat();
        do_reset();
        set_fares(9990, 5, 3);
        start_trip();
        for (int i = 0; i < 301; i++) drive_pulse();
        checks++;
        if (fare_bcd !== 16'h9995 || fare_max !== 1'b0) begin
            errors++;
            $display("FAIL sat_pre got fare=%h fmax=%b exp 9995 0", fare_bcd, fare_max);
        end
        drive_pulse();
        checks++;
        if (fare_bcd !== 16'h9999 || fare_max !== 1'b1 || state_o !== 2'b11) begin
            errors++;
            $display("FAIL sat_enter got fare=%h fmax=%b state=%b exp 9999 1 11", fare_bcd, fare_max, state_o);
        end
        for (int i = 0; i < 3; i++) drive_pulse();
        checks++;
        if (distance_bcd !== 16'h0305 || fare_bcd !== 16'h9999 || state_o !== 2'b11) begin
            errors++;
            $display("FAIL sat_hold got dist=%h fare=%h state=%b exp 0305 9999 11", distance_bcd, fare_bcd, state_o);
        end
    endtask

    task automatic test_hold_clr();
        do_reset();
        set_fares(800, 2, 3);
        start_trip();
        for (int i = 0; i < 310; i++) drive_pulse();
        wait_en = 1'b1;
        for (int i = 0; i < 17; i++) drive_pulse();
        wait_en = 1'b0; max_in = 1'b1;
        for (int i = 0; i < 17; i++) drive_pulse();
        max_in = 1'b0; en = 1'b0;
        for (int i = 0; i < 16; i++) drive_pulse();
        checks++;
        if (distance_bcd !== 16'h0310 || fare_bcd !== 16'h0820 || state_o !== 2'b10) begin
            errors++;
            $display("FAIL hold_frozen got dist=%h fare=%h state=%b exp 0310 0820 10", distance_bcd, fare_bcd, state_o);
        end
        // Resuming must not reload the start fare.
        en = 1'b1;
        drive_pulse();
        checks++;
        if (distance_bcd !== 16'h0311 || fare_bcd !== 16'h0822) begin
            errors++;
            $display("FAIL resume got dist=%h fare=%h exp 0311 0822", distance_bcd, fare_bcd);
        end
        // clr coinciding with the pulse event.
        pulse_in = 1'b1;
        repeat (2) @(posedge clk);
        #1 clr = 1'b1;
        @(posedge clk);
        #1 clr = 1'b0;
        m_dist = 0; m_fare = 0; m_state = 0; m_fmax = 1'b0; m_dmax = 1'b0;
        checks++;
        if (dut_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL clr_with_ev got=%h exp=%h", dut_vec(), exp_vec());
        end
        @(negedge clk) pulse_in = 1'b0;
        @(negedge clk);
        m_state = 1; m_fare = m_sf;
        checks++;
        if (state_o !== 2'b01 || fare_bcd !== 16'h0800 || distance_bcd !== 16'h0) begin
            errors++;
            $display("FAIL clr_rearm got state=%b fare=%h dist=%h exp 01 0800 0000", state_o, fare_bcd, distance_bcd);
        end
        @(negedge clk);
    endtask

    task automatic test_long_pulse_reset();
        logic [36:0] v_old;
        logic [36:0] v_new;
        do_reset();
        set_fares(800, 2, 3);
        start_trip();
        for (int i = 0; i < 305; i++) drive_pulse();
        v_old = exp_vec();
        pulse_in = 1'b1;
        model_count();
        v_new = exp_vec();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (dut_vec() !== v_old) begin
            errors++;
            $display("FAIL long_early got=%h exp=%h", dut_vec(), v_old);
        end
        @(posedge clk);
        #1;
        checks++;
        if (dut_vec() !== v_new) begin
            errors++;
            $display("FAIL long_latency got=%h exp=%h", dut_vec(), v_new);
        end
        repeat (97) @(posedge clk);
        #1;
        checks++;
        if (dut_vec() !== v_new) begin
            errors++;
            $display("FAIL long_once got=%h exp=%h", dut_vec(), v_new);
        end
        @(negedge clk) pulse_in = 1'b0;
        repeat (2) @(negedge clk);
        // Asynchronous reset well away from any rising edge.
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (dut_vec() !== 37'h0 || distance_km !== 8'h0) begin
            errors++;
            $display("FAIL async_reset got=%h km=%h exp all 0", dut_vec(), distance_km);
        end
        @(negedge clk);
        en = 1'b0;
        rst_n = 1'b1;
        m_dist = 0; m_fare = 0; m_state = 0; m_fmax = 1'b0; m_dmax = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_dist_sat();
        do_reset();
        set_fares(0, 0, 0);
        start_trip();
        for (int i = 0; i < 9998; i++) drive_pulse();
        checks++;
        if (distance_bcd !== 16'h9998 || fare_bcd !== 16'h0000 || state_o !== 2'b10) begin
            errors++;
            $display("FAIL dist_pre got dist=%h fare=%h state=%b exp 9998 0000 10", distance_bcd, fare_bcd, state_o);
        end
        set_fares(0, 0, 3);
        drive_pulse();
        checks++;
        if (distance_bcd !== 16'h9999 || fare_bcd !== 16'h0003) begin
            errors++;
            $display("FAIL dist_top got dist=%h fare=%h exp 9999 0003", distance_bcd, fare_bcd);
        end
        drive_pulse();
        checks++;
        if (distance_bcd !== 16'h9999 || dist_max !== 1'b1 || fare_bcd !== 16'h0006 || state_o !== 2'b10) begin
            errors++;
            $display("FAIL dist_sat got dist=%h dmax=%b fare=%h state=%b exp 9999 1 0006 10",
                     distance_bcd, dist_max, fare_bcd, state_o);
        end
    endtask

    initial begin : p_main
        @(negedge clk);
        test_reset();
        test_base_meter();
        test_fare_sat();
        test_hold_clr();
        test_long_pulse_reset();
        test_dist_sat();
        repeat (4) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_drain got %0d pending entries exp 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
